// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller: op codes,
// FSM state encodings and default busy-cycle counts.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  localparam int CNT_W          = 4;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32->64 multiply and 32/32 divide on latched operands.
// Division uses magnitudes so signed results truncate toward zero.
module mdu_arith (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [63:0] prod_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        div_zero_o
);

  logic        a_neg, b_neg;
  logic [63:0] a_ext, b_ext;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;

  always_comb begin
    a_neg      = signed_i & a_i[31];
    b_neg      = signed_i & b_i[31];
    // Low 64 bits of the extended product are correct for both signednesses.
    a_ext      = {{32{a_neg}}, a_i};
    b_ext      = {{32{b_neg}}, b_i};
    prod_o     = a_ext * b_ext;

    a_mag      = a_neg ? (32'd0 - a_i) : a_i;
    b_mag      = b_neg ? (32'd0 - b_i) : b_i;
    div_zero_o = (b_i == 32'd0);
    b_safe     = div_zero_o ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
    quot_o     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem_o      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: FSM, busy counter, operand latches and HI/LO.
// Optional cancel input enabled by defining MDU_CANCEL_EN.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             cancel_w;

  logic [63:0]      prod;
  logic [31:0]      quot, rem;
  logic             div_zero;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  mdu_arith u_arith (
    .a_i        (a_q),
    .b_i        (b_q),
    .signed_i   (sgn_q),
    .prod_o     (prod),
    .quot_o     (quot),
    .rem_o      (rem),
    .div_zero_o (div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_MULT);
              cnt_d   = CNT_W'(MUL_CYCLES);
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_DIV);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        // Cancel wins over a completion landing on the same edge.
        if (cancel_w) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            if (state_q == ST_MUL) begin
              hi_d = prod[63:32];
              lo_d = prod[31:0];
            end else if (!div_zero) begin
              hi_d = rem;
              lo_d = quot;
            end
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = (op == OP_MFHI) ? hi_q :
                 (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default MUL_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, rdata;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  int errors = 0;
  int checks = 0;

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start for one edge; returns in the first cycle after acceptance.
  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
  endtask

  // Counts consecutive busy cycles from the current one; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    op = OP_MFHI;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    op = OP_NONE;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int n;
    issue(OP_MULT, 32'd3, 32'hFFFFFFFE);
    a = 32'hAAAA5555; b = 32'h0;  // must not disturb latched operands
    for (int i = 1; i <= 5; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_c%0d got=%h exp=1", i, busy); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_done_busy got=%h exp=0", busy); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_cycles got=%0d exp=5", n); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_res got=%h exp=fffffffe00000001", {hi, lo}); end
  endtask

  task automatic test_div();
    int n;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL div_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    issue(OP_DIVU, 32'd7, 32'd2);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'd3 || hi !== 32'd1) begin errors++; $display("FAIL divu_res got hi=%h lo=%h exp hi=1 lo=3", hi, lo); end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    checks++; if (lo !== 32'h80000000 || hi !== 32'd0) begin errors++; $display("FAIL div_ovf got hi=%h lo=%h exp hi=0 lo=80000000", hi, lo); end
    issue(OP_DIVU, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    checks++; if (lo !== 32'd0 || hi !== 32'h80000000) begin errors++; $display("FAIL divu_big got hi=%h lo=%h exp hi=80000000 lo=0", hi, lo); end
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    count_busy(n);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin errors++; $display("FAIL div_negb got hi=%h lo=%h exp hi=1 lo=fffffffd", hi, lo); end
  endtask

  task automatic test_move_and_divzero();
    int n;
    issue(OP_MTHI, 32'h12345678, 32'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%h exp=0", busy); end
    op = OP_MFHI; start = 1'b1;
    #1;
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL mfhi_rdata got=%h exp=12345678", rdata); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== 32'h12345678) begin errors++; $display("FAIL mfhi_after got busy=%h hi=%h exp busy=0 hi=12345678", busy, hi); end
    issue(OP_MTLO, 32'hCAFEF00D, 32'd0);
    op = OP_MFLO;
    #1;
    checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL mflo_rdata got=%h exp=cafef00d", rdata); end
    op = OP_MULT;
    #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rdata_other got=%h exp=0", rdata); end
    op = OP_NONE;
    issue(OP_DIV, 32'd5, 32'd0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divz_cycles got=%0d exp=10", n); end
    checks++; if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin errors++; $display("FAIL divz_hilo got hi=%h lo=%h exp hi=12345678 lo=cafef00d", hi, lo); end
  endtask

  task automatic test_ignore_while_busy();
    int n;
    issue(OP_MULTU, 32'h00010000, 32'h00010003);
    start = 1'b1; op = OP_MTLO; a = 32'h0000DEAD;
    @(negedge clk);
    checks++; if (lo !== 32'hCAFEF00D) begin errors++; $display("FAIL busy_mtlo got=%h exp=cafef00d", lo); end
    op = OP_DIVU; a = 32'd7; b = 32'd2;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    count_busy(n);
    checks++; if (n != 3) begin errors++; $display("FAIL busy_remaining got=%0d exp=3", n); end
    checks++; if (hi !== 32'd1 || lo !== 32'h00030000) begin errors++; $display("FAIL busy_prod got hi=%h lo=%h exp hi=1 lo=30000", hi, lo); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_late_divu got=%h exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(OP_MULT, 32'd3, 32'd5);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_mid got busy=%h hi=%h lo=%h exp all 0", busy, hi, lo); end
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || lo !== 32'd0) begin errors++; $display("FAIL reset_discard got busy=%h lo=%h exp 0", busy, lo); end
    issue(OP_MULT, 32'd6, 32'd7);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL post_reset_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL post_reset_res got hi=%h lo=%h exp hi=0 lo=2a", hi, lo); end
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel();
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int i = 1; i < 10; i++) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%h exp=0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL cancel_hilo got hi=%h lo=%h exp hi=0 lo=2a", hi, lo); end
    cancel = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd4);
    cancel = 1'b0;
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL cancel_idle_start got=%0d exp=10", n); end
    checks++; if (hi !== 32'd1 || lo !== 32'd2) begin errors++; $display("FAIL cancel_idle_res got hi=%h lo=%h exp hi=1 lo=2", hi, lo); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_NONE; a = '0; b = '0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_move_and_divzero();
    test_ignore_while_busy();
    test_reset_mid();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
